// File: rtl/register_pipe_hs_pkg.sv
// Shared helpers for the handshaked register pipe.
// Optional feature macro: REGISTER_PIPE_HS_OCC_EN (occupancy counter port).
package svlib_pipe_pkg;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Per-stage control, kept as a struct so benches and debug taps can reuse it.
    typedef struct packed {
        logic vld;
    } stage_ctrl_t;

endpackage

// File: rtl/register_pipe_hs_stage.sv
// One pipe stage: a valid flop plus an enabled data flop.
// Optional feature macro: REGISTER_PIPE_HS_OCC_EN (not used in this file).
module register_pipe_stage
    import svlib_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    output stage_ctrl_t      o_ctrl,
    output logic [WIDTH-1:0] o_data
);

    logic             r_vld;
    logic [WIDTH-1:0] r_data;

    // Valid bit follows the upstream valid whenever this stage is ready; flush empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
        end else if (i_flush) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_vld <= i_up_valid;
        end
    end

    // Data only moves with a real beat so an empty stage keeps a stable value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load && i_up_valid && !i_flush) begin
            r_data <= i_up_data;
        end
    end

    assign o_ctrl.vld = r_vld;
    assign o_data     = r_data;

endmodule

// File: rtl/register_pipe_hs.sv
// N-stage valid/ready pipeline register with bubble collapse and synchronous flush.
// Optional feature macro: REGISTER_PIPE_HS_OCC_EN adds an "occupancy" output port.
//
// Handshake: a beat moves across an interface on a rising clk edge when its
// valid and ready are both 1; valid never waits on ready, and once m_valid is
// raised m_valid/m_data hold until m_ready, except on flush or reset.
module register_pipe_hs
    import svlib_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
`ifdef REGISTER_PIPE_HS_OCC_EN
    output logic [occ_width(DEPTH)-1:0] occupancy,
`endif
    output logic [WIDTH-1:0] m_data
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("register_pipe_hs: DEPTH must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("register_pipe_hs: WIDTH must be at least 1");
    end

    stage_ctrl_t      w_ctrl [DEPTH];
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0] w_vld;
    logic [DEPTH-1:0] w_rdy;

    // Ready ripples from the output back to the input; an empty stage is always ready.
    always_comb begin
        w_rdy            = '0;
        w_rdy[DEPTH-1]   = !w_vld[DEPTH-1] || m_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_rdy[i] = !w_vld[i] || w_rdy[i+1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        if (g == 0) begin : g_first
            assign w_up_valid = s_valid;
            assign w_up_data  = s_data;
        end else begin : g_inner
            assign w_up_valid = w_vld[g-1];
            assign w_up_data  = w_data[g-1];
        end

        register_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .i_flush    (flush),
            .i_load     (w_rdy[g]),
            .i_up_valid (w_up_valid),
            .i_up_data  (w_up_data),
            .o_ctrl     (w_ctrl[g]),
            .o_data     (w_data[g])
        );

        assign w_vld[g] = w_ctrl[g].vld;
    end

    // Flush blocks both interfaces combinationally so nothing transfers that cycle.
    assign s_ready = w_rdy[0] && !flush;
    assign m_valid = w_vld[DEPTH-1] && !flush;
    assign m_data  = w_data[DEPTH-1];

`ifdef REGISTER_PIPE_HS_OCC_EN
    logic                         w_accept;
    logic                         w_emit;
    logic [occ_width(DEPTH)-1:0]  r_occ;

    assign w_accept = s_valid && s_ready;
    assign w_emit   = m_valid && m_ready;

    // Beat counter: +1 per accept, -1 per emit, cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_accept && !w_emit) begin
            r_occ <= r_occ + 1'b1;
        end else if (w_emit && !w_accept) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    assign occupancy = r_occ;
`endif

endmodule
